// File: rtl/nb_reg_ctrl_if.sv
// rtl/nb_reg_ctrl_if.sv - bus bundle for the neighbour force-register controller (NB_REG_ERR_CHK_EN adds o_err)
interface nb_reg_ctrl_if #(
   parameter int NUM_FILTERS = 4
);
   localparam int CNT_W = $clog2(NUM_FILTERS + 1);

   logic                   i_alloc_valid;
   logic                   o_alloc_ready;
   logic [NUM_FILTERS-1:0] o_alloc_idx;
   logic [NUM_FILTERS-1:0] i_acc_req;
   logic [NUM_FILTERS-1:0] i_done;
   logic [NUM_FILTERS-1:0] o_reg_select;
   logic [NUM_FILTERS-1:0] o_release_select;
   logic                   i_release_ready;
   logic [CNT_W-1:0]       o_num_free;
`ifdef NB_REG_ERR_CHK_EN
   logic                   o_err;
`endif

   modport master (
      output i_alloc_valid, i_acc_req, i_done, i_release_ready,
      input  o_alloc_ready, o_alloc_idx, o_reg_select, o_release_select, o_num_free
`ifdef NB_REG_ERR_CHK_EN
      , input o_err
`endif
   );

   modport slave (
      input  i_alloc_valid, i_acc_req, i_done, i_release_ready,
      output o_alloc_ready, o_alloc_idx, o_reg_select, o_release_select, o_num_free
`ifdef NB_REG_ERR_CHK_EN
      , output o_err
`endif
   );
endinterface

// File: rtl/nb_reg_ctrl.sv
// rtl/nb_reg_ctrl.sv - neighbour force-register bank controller (NB_REG_ERR_CHK_EN adds sticky o_err)
module nb_reg_ctrl #(
   parameter int NUM_FILTERS = 4
) (
   input  logic         clk,
   input  logic         rst,
   nb_reg_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_FILTERS + 1);
   localparam int PTR_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam logic [PTR_W:0]         NF_EXT = (PTR_W + 1)'(NUM_FILTERS);
   localparam logic [NUM_FILTERS-1:0] ONE_N  = NUM_FILTERS'(1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b10
   } reg_state_t;

   reg_state_t             r_state [NUM_FILTERS];
   logic [PTR_W-1:0]       r_acc_ptr;
   logic [PTR_W-1:0]       r_rel_ptr;
   logic [PTR_W-1:0]       r_rel_idx;
   logic [NUM_FILTERS-1:0] r_reg_select;
   logic [NUM_FILTERS-1:0] r_rel_sel;
   logic [CNT_W-1:0]       r_num_free;

   logic [NUM_FILTERS-1:0] w_empty;
   logic [NUM_FILTERS-1:0] w_busy;
   logic [NUM_FILTERS-1:0] w_full;
   logic [NUM_FILTERS-1:0] w_alloc_oh;
   logic                   w_alloc_fire;
   logic [NUM_FILTERS-1:0] w_acc_elig;
   logic                   w_acc_found;
   logic [PTR_W-1:0]       w_acc_idx;
   logic                   w_rel_found;
   logic [PTR_W-1:0]       w_rel_idx;
   logic                   w_rel_offer;
   logic                   w_rel_fire;

   // Index + 1 with wrap from NUM_FILTERS-1 back to 0.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
      logic [PTR_W:0] nxt;
      nxt = {1'b0, idx} + (PTR_W + 1)'(1);
      if (nxt >= NF_EXT) nxt = '0;
      return nxt[PTR_W-1:0];
   endfunction

   // Round-robin pick: rotate requests so ptr lands at bit 0, take the lowest
   // set bit, then map the offset back to an absolute index. Returns {found, idx}.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_FILTERS-1:0] req,
                                              input logic [PTR_W-1:0]       ptr);
      logic [2*NUM_FILTERS-1:0] dbl;
      logic [NUM_FILTERS-1:0]   rot;
      logic [PTR_W:0]           off;
      logic [PTR_W:0]           sum;
      dbl = {req, req} >> ptr;
      rot = dbl[NUM_FILTERS-1:0];
      off = '0;
      for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
         if (rot[k]) off = (PTR_W + 1)'(k);
      end
      sum = {1'b0, ptr} + off;
      if (sum >= NF_EXT) sum = sum - NF_EXT;
      return {|rot, sum[PTR_W-1:0]};
   endfunction

   // Decode per-register state into EMPTY/BUSY/FULL bit vectors.
   always_comb begin
      w_empty = '0;
      w_busy  = '0;
      w_full  = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         w_empty[i] = (r_state[i] == ST_EMPTY);
         w_busy[i]  = (r_state[i] == ST_BUSY);
         w_full[i]  = (r_state[i] == ST_FULL);
      end
   end

   // Lowest-index EMPTY register is the allocation candidate (isolate lowest set bit).
   assign w_alloc_oh   = w_empty & (~w_empty + ONE_N);
   assign w_alloc_fire = bus.i_alloc_valid & (|w_empty);

   // Only BUSY registers may accumulate; FULL (released) ones are excluded by construction.
   assign w_acc_elig                = bus.i_acc_req & w_busy;
   assign {w_acc_found, w_acc_idx}  = rr_pick(w_acc_elig, r_acc_ptr);
   assign {w_rel_found, w_rel_idx}  = rr_pick(w_full, r_rel_ptr);

   assign w_rel_offer = |r_rel_sel;
   assign w_rel_fire  = w_rel_offer & bus.i_release_ready;

   assign bus.o_alloc_ready    = |w_empty;
   assign bus.o_alloc_idx      = w_alloc_oh;
   assign bus.o_reg_select     = r_reg_select;
   assign bus.o_release_select = r_rel_sel;
   assign bus.o_num_free       = r_num_free;

   // Per-register lifecycle EMPTY -> BUSY -> FULL -> EMPTY.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FILTERS; i++) r_state[i] <= ST_EMPTY;
      end else begin
         for (int i = 0; i < NUM_FILTERS; i++) begin
            case (r_state[i])
               ST_EMPTY: if (w_alloc_fire && w_alloc_oh[i])  r_state[i] <= ST_BUSY;
               ST_BUSY:  if (bus.i_done[i])                  r_state[i] <= ST_FULL;
               ST_FULL:  if (w_rel_fire && r_rel_sel[i])     r_state[i] <= ST_EMPTY;
               default:                                      r_state[i] <= ST_EMPTY;
            endcase
         end
      end
   end

   // Registered accumulate grant and its round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_select <= '0;
         r_acc_ptr    <= '0;
      end else begin
         r_reg_select <= w_acc_found ? (ONE_N << w_acc_idx) : '0;
         if (w_acc_found) r_acc_ptr <= wrap_inc(w_acc_idx);
      end
   end

   // Release offer: latch a FULL register, hold it until accepted, then rest one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rel_sel <= '0;
         r_rel_idx <= '0;
         r_rel_ptr <= '0;
      end else if (w_rel_fire) begin
         r_rel_sel <= '0;
         r_rel_ptr <= wrap_inc(r_rel_idx);
      end else if (!w_rel_offer && w_rel_found) begin
         r_rel_sel <= ONE_N << w_rel_idx;
         r_rel_idx <= w_rel_idx;
      end
   end

   // Free-register count tracks allocation and release on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_num_free <= CNT_W'(NUM_FILTERS);
      end else begin
         case ({w_alloc_fire, w_rel_fire})
            2'b10:   r_num_free <= r_num_free - CNT_W'(1);
            2'b01:   r_num_free <= r_num_free + CNT_W'(1);
            default: r_num_free <= r_num_free;
         endcase
      end
   end

`ifdef NB_REG_ERR_CHK_EN
   logic r_err;
   assign bus.o_err = r_err;

   // Sticky protocol-violation flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if ((|(bus.i_acc_req & ~w_busy)) ||
                   (|(bus.i_done & ~w_busy)) ||
                   (bus.i_alloc_valid && !(|w_empty))) begin
         r_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_nb_reg_ctrl.sv
// tb/tb_nb_reg_ctrl.sv - directed self-checking bench for nb_reg_ctrl
module tb_nb_reg_ctrl;
   localparam int NF = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;

   logic [3:0] alloc_seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] acc_seq   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   nb_reg_ctrl_if #(.NUM_FILTERS(NF)) bus ();

   nb_reg_ctrl #(.NUM_FILTERS(NF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst                 = 1'b1;
      bus.i_alloc_valid   = 1'b0;
      bus.i_acc_req       = '0;
      bus.i_done          = '0;
      bus.i_release_ready = 1'b0;
      step();
      step();

      chk("rst_num_free",    32'(bus.o_num_free), 32'd4);
      chk("rst_alloc_ready", 32'(bus.o_alloc_ready), 32'd1);
      chk("rst_alloc_idx",   32'(bus.o_alloc_idx), 32'b0001);
      chk("rst_reg_select",  32'(bus.o_reg_select), 32'd0);
      chk("rst_rel_select",  32'(bus.o_release_select), 32'd0);
`ifdef NB_REG_ERR_CHK_EN
      chk("rst_err",         32'(bus.o_err), 32'd0);
`endif
      rst = 1'b0;

      // four back-to-back allocations fill the bank
      bus.i_alloc_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("alloc_idx",  32'(bus.o_alloc_idx), 32'(alloc_seq[k]));
         step();
         chk("alloc_free", 32'(bus.o_num_free), 32'(3 - k));
      end
      bus.i_alloc_valid = 1'b0;
      chk("full_alloc_ready", 32'(bus.o_alloc_ready), 32'd0);
      chk("full_alloc_idx",   32'(bus.o_alloc_idx), 32'd0);

      // round-robin accumulate, one cycle latency
      bus.i_acc_req = 4'b1111;
      chk("acc_latency", 32'(bus.o_reg_select), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("acc_rr", 32'(bus.o_reg_select), 32'(acc_seq[k]));
      end
      bus.i_acc_req = '0;
      step();
      chk("acc_idle", 32'(bus.o_reg_select), 32'd0);

      // done on regs 0 and 2, offer held while not ready
      bus.i_done = 4'b0101;
      step();
      bus.i_done = '0;
      chk("rel_not_yet", 32'(bus.o_release_select), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rel_hold", 32'(bus.o_release_select), 32'b0001);
      end
      chk("rel_hold_free", 32'(bus.o_num_free), 32'd0);
      bus.i_release_ready = 1'b1;
      step();
      chk("rel_acc_free", 32'(bus.o_num_free), 32'd1);
      chk("rel_gap",      32'(bus.o_release_select), 32'd0);
      step();
      chk("rel_next",     32'(bus.o_release_select), 32'b0100);
      step();
      chk("rel2_free",    32'(bus.o_num_free), 32'd2);
      chk("rel2_gap",     32'(bus.o_release_select), 32'd0);
      bus.i_release_ready = 1'b0;

      // refill regs 0 and 2
      bus.i_alloc_valid = 1'b1;
      chk("refill_idx0", 32'(bus.o_alloc_idx), 32'b0001);
      step();
      chk("refill_free1", 32'(bus.o_num_free), 32'd1);
      chk("refill_idx2", 32'(bus.o_alloc_idx), 32'b0100);
      step();
      chk("refill_free0", 32'(bus.o_num_free), 32'd0);
      bus.i_alloc_valid = 1'b0;

      // release of reg 0 coincides with alloc request while bank is full
      bus.i_done = 4'b0001;
      step();
      bus.i_done = '0;
      step();
      chk("coll_offer",  32'(bus.o_release_select), 32'b0001);
      chk("coll_ready0", 32'(bus.o_alloc_ready), 32'd0);
      bus.i_release_ready = 1'b1;
      bus.i_alloc_valid   = 1'b1;
      step();
      chk("coll_free",      32'(bus.o_num_free), 32'd1);
      chk("coll_rel_clear", 32'(bus.o_release_select), 32'd0);
      chk("coll_ready1",    32'(bus.o_alloc_ready), 32'd1);
      chk("coll_idx",       32'(bus.o_alloc_idx), 32'b0001);
      bus.i_release_ready = 1'b0;
      step();
      chk("coll_granted",   32'(bus.o_num_free), 32'd0);
      chk("coll_ready_end", 32'(bus.o_alloc_ready), 32'd0);
      bus.i_alloc_valid = 1'b0;

      // done and grant on the same register, then reset mid-operation
      bus.i_done    = 4'b0010;
      bus.i_acc_req = 4'b1111;
      step();
      bus.i_done = '0;
      chk("done_grant",  32'(bus.o_reg_select), 32'b0010);
      step();
      chk("skip_full",   32'(bus.o_reg_select), 32'b0100);
      chk("mid_offer",   32'(bus.o_release_select), 32'b0010);
      rst = 1'b1;
      step();
      chk("mid_rst_sel",   32'(bus.o_reg_select), 32'd0);
      chk("mid_rst_rel",   32'(bus.o_release_select), 32'd0);
      chk("mid_rst_free",  32'(bus.o_num_free), 32'd4);
      chk("mid_rst_idx",   32'(bus.o_alloc_idx), 32'b0001);
      rst           = 1'b0;
      bus.i_acc_req = '0;
      step();

      // request to an EMPTY register gets no grant
      bus.i_acc_req = 4'b0001;
      step();
      chk("acc_empty_sel", 32'(bus.o_reg_select), 32'd0);
      bus.i_acc_req = '0;
      step();
      chk("acc_empty_sel2", 32'(bus.o_reg_select), 32'd0);
`ifdef NB_REG_ERR_CHK_EN
      chk("err_set",    32'(bus.o_err), 32'd1);
      step();
      chk("err_sticky", 32'(bus.o_err), 32'd1);
`endif

      // done on EMPTY registers is ignored
      bus.i_done = 4'b1111;
      step();
      bus.i_done = '0;
      step();
      step();
      chk("done_empty_rel",  32'(bus.o_release_select), 32'd0);
      chk("done_empty_free", 32'(bus.o_num_free), 32'd4);

`ifdef NB_REG_ERR_CHK_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("err_cleared", 32'(bus.o_err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
